// File: rtl/pixel_coord_gen_pkg.sv
// Shared raster constants and state encoding for the pixel coordinate generator.
// NUM_PIXELS/COORD_WIDTH defaults are shared with the pixel processor;
// H_VISIBLE/V_VISIBLE defaults are shared with the timing generator.
package pixel_coord_gen_pkg;

    localparam int unsigned DEF_NUM_PIXELS  = 8;
    localparam int unsigned DEF_H_VISIBLE   = 640;
    localparam int unsigned DEF_V_VISIBLE   = 480;
    localparam int unsigned DEF_COORD_WIDTH = 10;
    localparam int unsigned DEF_FRAME_WIDTH = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDone   = 2'd2
    } coord_state_e;

endpackage

// File: rtl/pixel_coord_gen.sv
// Pixel coordinate generator: issues the raster coordinates of each batch of
// NUM_PIXELS pixels processed in parallel.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   new_frame          - one-cycle frame-start strobe (restarts at (0,0))
//   start_next_batch   - consume current batch and advance
//   batch_valid        - current coordinates are valid
//   batch_x, batch_y   - x of lane 0 and line number
//   lane_x             - per-lane x, lane i at [i*COORD_WIDTH +: COORD_WIDTH]
//   last_in_line       - current batch ends the line
//   last_in_frame      - current batch ends the frame
//   frame_count        - frame number (first frame after reset is 0)
module pixel_coord_gen
    import pixel_coord_gen_pkg::*;
#(
    parameter int unsigned NUM_PIXELS  = DEF_NUM_PIXELS,
    parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
    parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
    parameter int unsigned COORD_WIDTH = DEF_COORD_WIDTH,
    parameter int unsigned FRAME_WIDTH = DEF_FRAME_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              new_frame,
    input  logic                              start_next_batch,
    output logic                              batch_valid,
    output logic [COORD_WIDTH-1:0]            batch_x,
    output logic [COORD_WIDTH-1:0]            batch_y,
    output logic [NUM_PIXELS*COORD_WIDTH-1:0] lane_x,
    output logic                              last_in_line,
    output logic                              last_in_frame,
    output logic [FRAME_WIDTH-1:0]            frame_count
);

    // Parameter sanity: these bounds are what let the x/y adders drop carry-out.
    if (H_VISIBLE % NUM_PIXELS != 0) begin : g_bad_h_visible
        $fatal(1, "pixel_coord_gen: H_VISIBLE must be a multiple of NUM_PIXELS");
    end
    if ((H_VISIBLE - 1) >= (2 ** COORD_WIDTH) || (V_VISIBLE - 1) >= (2 ** COORD_WIDTH))
    begin : g_bad_coord_width
        $fatal(1, "pixel_coord_gen: COORD_WIDTH too narrow for raster size");
    end

    localparam logic [COORD_WIDTH-1:0] LastX = COORD_WIDTH'(H_VISIBLE - NUM_PIXELS);
    localparam logic [COORD_WIDTH-1:0] LastY = COORD_WIDTH'(V_VISIBLE - 1);
    localparam logic [COORD_WIDTH-1:0] StepX = COORD_WIDTH'(NUM_PIXELS);

    coord_state_e            state_q, state_d;
    logic [COORD_WIDTH-1:0]  x_q, x_d;
    logic [COORD_WIDTH-1:0]  y_q, y_d;
    logic [FRAME_WIDTH-1:0]  frame_q, frame_d;
    logic                    at_line_end;
    logic                    at_frame_end;

    // Raw compares on the registered position; outputs gate them with validity.
    assign at_line_end  = (x_q == LastX);
    assign at_frame_end = at_line_end && (y_q == LastY);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
        end
    end

    // Next-state logic; new_frame dominates start_next_batch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        if (new_frame) begin
            state_d = StActive;
            x_d     = '0;
            y_d     = '0;
            // Leaving IDLE starts frame 0; any later frame start counts up.
            if (state_q != StIdle) begin
                frame_d = frame_q + FRAME_WIDTH'(1);
            end
        end else if (start_next_batch && state_q == StActive) begin
            if (at_frame_end) begin
                state_d = StDone;
            end else if (at_line_end) begin
                x_d = '0;
                y_d = y_q + COORD_WIDTH'(1);
            end else begin
                x_d = x_q + StepX;
            end
        end
    end

    // Outputs, all derived from registered state.
    always_comb begin
        batch_valid   = (state_q == StActive);
        batch_x       = x_q;
        batch_y       = y_q;
        frame_count   = frame_q;
        last_in_line  = batch_valid && at_line_end;
        last_in_frame = batch_valid && at_frame_end;
    end

    for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_lane
        assign lane_x[i*COORD_WIDTH +: COORD_WIDTH] = x_q + COORD_WIDTH'(i);
    end

endmodule

// File: tb/tb_pixel_coord_gen.sv
module tb_pixel_coord_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_frame;
    logic        start_next_batch;
    logic        batch_valid;
    logic [9:0]  batch_x;
    logic [9:0]  batch_y;
    logic [79:0] lane_x;
    logic        last_in_line;
    logic        last_in_frame;
    logic [15:0] frame_count;

    pixel_coord_gen dut (
        .clk              (clk),
        .reset            (reset),
        .new_frame        (new_frame),
        .start_next_batch (start_next_batch),
        .batch_valid      (batch_valid),
        .batch_x          (batch_x),
        .batch_y          (batch_y),
        .lane_x           (lane_x),
        .last_in_line     (last_in_line),
        .last_in_frame    (last_in_frame),
        .frame_count      (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic nf;
        logic st;
        logic v;
        int   x;
        int   y;
        logic lil;
        logic lif;
        int   fc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_outs(input string name, input logic v, input int x, input int y,
                              input logic lil, input logic lif, input int fc);
        check({name, ".valid"}, 32'(batch_valid), 32'(v));
        check({name, ".x"}, 32'(batch_x), x);
        check({name, ".y"}, 32'(batch_y), y);
        check({name, ".last_in_line"}, 32'(last_in_line), 32'(lil));
        check({name, ".last_in_frame"}, 32'(last_in_frame), 32'(lif));
        check({name, ".frame_count"}, 32'(frame_count), fc);
    endtask

    // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic nf, input logic st);
        new_frame        = nf;
        start_next_batch = st;
        @(posedge clk);
        #1;
        new_frame        = 1'b0;
        start_next_batch = 1'b0;
    endtask

    // Issue n starts within an active frame, comparing against a raster model each cycle.
    task automatic walk(input int n, inout int x, inout int y, output int bad);
        logic exp_lil;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1);
            x = x + 8;
            if (x == 640) begin
                x = 0;
                y = y + 1;
            end
            exp_lil = (x == 632);
            if (batch_valid !== 1'b1 || int'(batch_x) != x || int'(batch_y) != y ||
                last_in_line !== exp_lil || last_in_frame !== (exp_lil && y == 479) ||
                int'(lane_x[70 +: 10]) != x + 7)
                bad++;
        end
    endtask

    initial begin
        int x;
        int y;
        int bad;

        vecs[0] = '{nf: 0, st: 1, v: 0, x: 0,  y: 0, lil: 0, lif: 0, fc: 0};
        vecs[1] = '{nf: 0, st: 1, v: 0, x: 0,  y: 0, lil: 0, lif: 0, fc: 0};
        vecs[2] = '{nf: 1, st: 0, v: 1, x: 0,  y: 0, lil: 0, lif: 0, fc: 0};
        vecs[3] = '{nf: 0, st: 1, v: 1, x: 8,  y: 0, lil: 0, lif: 0, fc: 0};
        vecs[4] = '{nf: 0, st: 0, v: 1, x: 8,  y: 0, lil: 0, lif: 0, fc: 0};
        vecs[5] = '{nf: 0, st: 1, v: 1, x: 16, y: 0, lil: 0, lif: 0, fc: 0};
        vecs[6] = '{nf: 1, st: 1, v: 1, x: 0,  y: 0, lil: 0, lif: 0, fc: 1};
        vecs[7] = '{nf: 0, st: 1, v: 1, x: 8,  y: 0, lil: 0, lif: 0, fc: 1};

        reset            = 1'b1;
        new_frame        = 1'b0;
        start_next_batch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_outs("reset", 1'b0, 0, 0, 1'b0, 1'b0, 0);
        check("reset.lane7", 32'(lane_x[70 +: 10]), 7);

        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        check_outs("idle_starts", 1'b0, 0, 0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].nf, vecs[i].st);
            check_outs($sformatf("vec%0d", i), vecs[i].v, vecs[i].x, vecs[i].y,
                       vecs[i].lil, vecs[i].lif, vecs[i].fc);
        end

        // Fresh frame 0, walk the first line.
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        step(1'b1, 1'b0);
        check_outs("frame0_start", 1'b1, 0, 0, 1'b0, 1'b0, 0);
        x = 0;
        y = 0;
        walk(79, x, y, bad);
        check("line0_walk_errors", bad, 0);
        check_outs("line0_end", 1'b1, 632, 0, 1'b1, 1'b0, 0);
        check("line0_end.lane0", 32'(lane_x[0 +: 10]), 632);
        check("line0_end.lane7", 32'(lane_x[70 +: 10]), 639);
        walk(1, x, y, bad);
        check_outs("line1_start", 1'b1, 0, 1, 1'b0, 1'b0, 0);

        walk(38400 - 81, x, y, bad);
        check("frame0_walk_errors", bad, 0);
        check_outs("frame0_last", 1'b1, 632, 479, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1);
        check_outs("frame0_done", 1'b0, 632, 479, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1);
        check_outs("done_start_ignored", 1'b0, 632, 479, 1'b0, 1'b0, 0);

        step(1'b1, 1'b0);
        check_outs("frame1_start", 1'b1, 0, 0, 1'b0, 1'b0, 1);
        x = 0;
        y = 0;
        walk(38399, x, y, bad);
        check("frame1_walk_errors", bad, 0);
        check_outs("frame1_last", 1'b1, 632, 479, 1'b1, 1'b1, 1);
        step(1'b0, 1'b1);
        check_outs("frame1_done", 1'b0, 632, 479, 1'b0, 1'b0, 1);
        step(1'b1, 1'b0);
        check_outs("frame2_start", 1'b1, 0, 0, 1'b0, 1'b0, 2);

        // Simultaneous strobes at (96,5): restart wins, no advance to 104.
        x = 0;
        y = 0;
        walk(5 * 80 + 12, x, y, bad);
        check_outs("at_96_5", 1'b1, 96, 5, 1'b0, 1'b0, 2);
        step(1'b1, 1'b1);
        check_outs("both_strobes", 1'b1, 0, 0, 1'b0, 1'b0, 3);

        // Reset mid-frame at (200,100).
        x = 0;
        y = 0;
        walk(100 * 80 + 25, x, y, bad);
        check_outs("at_200_100", 1'b1, 200, 100, 1'b0, 1'b0, 3);
        reset = 1'b1;
        step(1'b0, 1'b1);
        reset = 1'b0;
        check_outs("midframe_reset", 1'b0, 0, 0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0);
        check_outs("after_reset_frame", 1'b1, 0, 0, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_coord_gen.md
Name: pixel_coord_gen

Overview:
Generates the screen coordinates of each batch of NUM_PIXELS pixels that the pixel processor computes in parallel.
- Sits directly upstream of the pixel processor and is driven by the same new_frame and start_next_batch strobes that pace the pixel FIFO.
- Produces a base (x, y), per-lane x values, line/frame boundary flags and a frame counter for animation.
- Keeps the processor free of raster bookkeeping.

Parameters:
- NUM_PIXELS, 8: pixels per batch (lanes).
- H_VISIBLE, 640: visible pixels per line; must be a multiple of NUM_PIXELS (elaboration-time check, fatal if violated).
- V_VISIBLE, 480: visible lines per frame.
- COORD_WIDTH, 10: width of x/y coordinates; must hold H_VISIBLE-1 and V_VISIBLE-1.
- FRAME_WIDTH, 16: width of the frame counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- new_frame, input, 1: one-cycle strobe at frame start, from the timing generator.
- start_next_batch, input, 1: consume the current batch and advance.
- batch_valid, output, 1: current coordinates are valid.
- batch_x, output, COORD_WIDTH: x of lane 0.
- batch_y, output, COORD_WIDTH: line number.
- lane_x, output, NUM_PIXELS*COORD_WIDTH: lane i at bits [i*COORD_WIDTH +: COORD_WIDTH], equal to batch_x+i.
- last_in_line, output, 1: batch_x == H_VISIBLE-NUM_PIXELS.
- last_in_frame, output, 1: last_in_line and batch_y == V_VISIBLE-1.
- frame_count, output, FRAME_WIDTH: frame number.

Behaviour:
- All outputs are registered. Reset (highest priority): state IDLE, batch_x=0, batch_y=0, frame_count=0, batch_valid=0. Flags are 0 and lane_x reflects x=0.
- States:
  - IDLE: after reset, waiting for the first new_frame.
  - ACTIVE: batches are being issued.
  - DONE: the last batch of the frame has been consumed.
- new_frame in any state: next cycle x=0, y=0, state ACTIVE, batch_valid=1.
  - frame_count increments (wraps modulo 2^FRAME_WIDTH) when new_frame arrives in ACTIVE or DONE.
  - frame_count does not increment on the IDLE->ACTIVE transition, so the first frame is 0.
- start_next_batch in ACTIVE without new_frame (single-cycle latency; new values are visible the next cycle):
  - not last_in_line: x += NUM_PIXELS.
  - last_in_line and not last_in_frame: x=0, y += 1.
  - last_in_frame: state DONE, batch_valid=0; x/y hold their final values.
- new_frame and start_next_batch in the same cycle: new_frame wins and the start is discarded.
- start_next_batch in IDLE or DONE: ignored, no state change.
- new_frame mid-frame (ACTIVE, not at last batch): abandon the frame and restart at (0,0). frame_count increments.
- Reset mid-frame: return to IDLE immediately. A following new_frame starts frame 0.
- Arithmetic is unsigned; the x/y adders need no carry-out because parameter checks bound the range.
- last_in_line and last_in_frame are combinational compares of the registered x/y against constants, or registered with equivalent timing. Both are gated by batch_valid (0 when invalid).
- Throughput: one batch per cycle if start_next_batch is held high.

Decomposition:
- Shared package holds:
  - COORD_WIDTH and NUM_PIXELS defaults shared with the pixel processor.
  - The H_VISIBLE/V_VISIBLE raster constants shared with the timing generator.
  - The state encoding (IDLE, ACTIVE, DONE).
- No sub-module required. lane_x generation is a generate loop inside this module.

Test Plan:
- Reset, then idle 10 cycles -> batch_valid=0, x=0, y=0, frame_count=0. start_next_batch pulses ignored.
- new_frame, then 80 consecutive start_next_batch -> x steps 0,8,...,632 with last_in_line=1 at 632. After the 80th start: x=0, y=1. lane_x lane 7 = 639 at x=632.
- Full frame: 38400 starts -> final batch (632,479) with last_in_frame=1. Next cycle batch_valid=0 and state DONE; further starts are ignored.
- new_frame in DONE -> (0,0), batch_valid=1, frame_count 0->1. Repeat a second time -> 2.
- At (96,5), assert new_frame and start_next_batch in the same cycle -> next cycle (0,0), frame_count +1, no advance to 104.
- Reset asserted at (200,100) mid-frame -> next cycle IDLE, batch_valid=0, frame_count=0. The following new_frame yields frame 0 at (0,0).
